// File: rtl/bitset_scan_encoder_pkg.sv
// Shared types and constant math for the bitset scan encoder.
// Index width rules and the single-bit check live here.
package bitset_scan_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Ceiling log2 with a floor of 1 so a 1-wide vector still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit is_single_bit(input longint v);
    return (v != 64'sd0) && ((v & (v - 64'sd1)) == 64'sd0);
  endfunction

endpackage

// File: rtl/bitset_scan_encoder_priority_isolate.sv
// Isolates the lowest (or, with HIGH_FIRST, the highest) set bit of a vector
// and returns both that one-hot bit and the vector with it cleared.
module priority_isolate #(
  parameter int N          = 8,
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic [N-1:0] cleared
);

  logic [N-1:0] work_s;
  logic [N-1:0] iso_s;

  // Highest-first reuses the lowest-bit trick on a mirrored vector.
  always_comb begin
    work_s = {N{1'b0}};
    onehot = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (HIGH_FIRST) begin
        work_s[i] = vec[N-1-i];
      end else begin
        work_s[i] = vec[i];
      end
    end
    iso_s = work_s & (~work_s + N'(1));
    for (int i = 0; i < N; i++) begin
      if (HIGH_FIRST) begin
        onehot[i] = iso_s[N-1-i];
      end else begin
        onehot[i] = iso_s[i];
      end
    end
  end

  assign cleared = vec & ~onehot;

endmodule

// File: rtl/bitset_scan_encoder.sv
// Streams out the index of every set bit of a loaded vector, one per cycle,
// over a valid/ready interface; a final pop can overlap the next load.
module bitset_scan_encoder
  import bitset_scan_encoder_pkg::*;
#(
  parameter int  N          = 8,
  parameter bit  HIGH_FIRST = 1'b0,
  localparam int IW         = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [N-1:0]  load_vec,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          empty_pulse,
  output logic          busy
);

  scan_state_t   state_r, state_n;
  logic [N-1:0]  pending_r, pending_n;
  logic          empty_r, empty_n;
  logic [N-1:0]  onehot_s;
  logic [N-1:0]  cleared_s;
  logic [IW-1:0] enc_s;
  logic          last_s;
  logic          scanning_s;

  priority_isolate #(
    .N          (N),
    .HIGH_FIRST (HIGH_FIRST)
  ) u_isolate (
    .vec     (pending_r),
    .onehot  (onehot_s),
    .cleared (cleared_s)
  );

  // One-hot to binary index; only indices below N can ever be produced.
  always_comb begin
    enc_s = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (onehot_s[i]) begin
        enc_s = enc_s | IW'(i);
      end else begin
        enc_s = enc_s;
      end
    end
  end

  assign scanning_s  = (state_r == SCAN);
  assign last_s      = scanning_s && (cleared_s == {N{1'b0}});
  assign out_valid   = scanning_s;
  assign out_idx     = scanning_s ? enc_s : {IW{1'b0}};
  assign out_last    = last_s;
  assign busy        = scanning_s;
  assign empty_pulse = empty_r;
  assign load_ready  = !scanning_s || (out_ready && last_s);

  // Next-state: a load during the final pop chains straight into a new scan.
  always_comb begin
    state_n   = state_r;
    pending_n = pending_r;
    empty_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_valid) begin
          if (load_vec != {N{1'b0}}) begin
            pending_n = load_vec;
            state_n   = SCAN;
          end else begin
            empty_n = 1'b1;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SCAN: begin
        if (out_ready) begin
          pending_n = cleared_s;
          if (last_s) begin
            if (load_valid && (load_vec != {N{1'b0}})) begin
              pending_n = load_vec;
              state_n   = SCAN;
            end else begin
              empty_n = load_valid;
              state_n = IDLE;
            end
          end else begin
            state_n = SCAN;
          end
        end else begin
          pending_n = pending_r;
        end
      end
      default: begin
        state_n   = IDLE;
        pending_n = {N{1'b0}};
      end
    endcase
  end

  // State, pending bits and the empty pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      pending_r <= {N{1'b0}};
      empty_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      pending_r <= pending_n;
      empty_r   <= empty_n;
    end
  end

endmodule

// File: doc/bitset_scan_encoder.md
Name: bitset_scan_encoder

Overview:
- Sequential successor to the combinational one-hot encoder: accepts an N-bit vector with any number of bits set and emits the index of every set bit, one per cycle, over a valid/ready stream.
- Scan order is selectable: lowest-first or highest-first.
- Used by the solver to walk literal/clause bitmaps, such as unassigned variables or unsatisfied clauses, without a full priority tree per consumer.

Parameters:
- N, 8, vector width; N >= 1.
- HIGH_FIRST, 0, scan order: 0 emits lowest set index first, 1 emits highest first.
- IW, log2(N), index width; derived localparam from the shared math include, not user-set.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  producer offers load_vec.
- load_ready  output  1  block can accept a vector this cycle.
- load_vec  input  N  bitset to scan.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  IW  index of the current set bit.
- out_last  output  1  out_idx is the final set bit of this vector.
- empty_pulse  output  1  one-cycle pulse: an accepted vector was all zero.
- busy  output  1  scan in progress (state == SCAN).

Behaviour:
- Reset:
  - One clock, reset synchronous and active-high. Reset wins over every other input in the same cycle.
  - Reset values: state=IDLE, pending=0, out_valid=0, out_last=0, empty_pulse=0, busy=0, load_ready=1 in the cycle after reset is released. out_idx=0 while out_valid=0.
- Registers:
  - pending[N-1:0] holds the bits not yet emitted.
  - State is a 2-state FSM, IDLE and SCAN, held in 1 bit.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid with load_vec != 0: pending <= load_vec, next state SCAN.
  - On load_valid with load_vec == 0: empty_pulse=1 in the following cycle only, stay IDLE.
- SCAN:
  - out_valid=1 every cycle.
  - out_idx = priority index of pending: lowest set bit when HIGH_FIRST=0, highest when HIGH_FIRST=1. Combinational from the pending register.
  - out_last=1 iff exactly one bit of pending is set.
  - On out_valid & out_ready: the selected bit is cleared in pending.
    - If out_last=1, next state is IDLE.
    - Otherwise stay in SCAN.
  - If out_ready=0, out_idx and out_last hold stable.
- Latency and throughput:
  - Vector accepted on edge t gives first out_valid in cycle t+1.
  - One index per cycle while out_ready=1.
  - A vector with k set bits completes in k cycles of out_ready.
- Back-to-back loads:
  - load_ready = (state==IDLE) | (state==SCAN & out_ready & out_last).
  - A load accepted in the same cycle as the final pop moves directly into SCAN with the new pending, so there is no idle bubble.
  - load_ready is combinational on out_ready; the producer must not make load_valid depend on load_ready.
- Other boundary rules:
  - load_vec is ignored when load_ready=0.
  - Duplicate indices are never emitted.
  - N=1 gives IW=1 and out_idx tied to 0. A vector of 1 gives a single beat with out_last=1.
  - Width of IW follows the shared log2 (ceiling, minimum 1). out_idx never exceeds N-1 for non-power-of-two N.

Decomposition:
- Shared include: the existing log2 function. Add a constant function for the popcount-equals-one check, if it is not already present.
- Sub-module priority_isolate:
  - Parameters N and HIGH_FIRST; combinational.
  - HIGH_FIRST=0: isolates the lowest set bit, vec & (~vec + 1).
  - HIGH_FIRST=1: bit-reverses, isolates, then bit-reverses back.
  - Output is one-hot, plus the mask with that bit cleared.
- The one-hot output of priority_isolate feeds the existing one-hot encoder module to produce out_idx.
- out_last = (pending_after_clear == 0).

Test Plan:
1. N=8, HIGH_FIRST=0: load 8'b1010_0110, out_ready=1 -> out_idx 1,2,5,7 on consecutive cycles starting 1 cycle after load; out_last=1 only on 7; busy falls the cycle after.
2. N=8, HIGH_FIRST=1: load 8'b1010_0110 -> out_idx 7,5,2,1.
3. Load 8'h00 -> empty_pulse high exactly 1 cycle, out_valid never asserts, load_ready stays 1.
4. Backpressure: load 8'h81, hold out_ready=0 for 3 cycles -> out_idx=0 stable, out_last=0; release -> 0 then 7 (out_last=1).
5. Back-to-back: during the final beat of 8'h10, present load 8'h03 -> load accepted that cycle; next cycles emit 0,1 with no gap.
6. Reset mid-scan after the first pop of 8'hFF -> next cycle out_valid=0, load_ready=1; a new load of 8'h04 emits only index 2. Repeat case 1 with N=5 and vector 5'b10001 -> indices 0,4, IW=3.
